// File: rtl/mem_mover_pkg.sv
// Shared definitions for the memory mover: default widths, mode codes and
// FSM state encoding.
package mem_mover_pkg;

    localparam int AW_DEFAULT = 4;
    localparam int DW_DEFAULT = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } stateT;

endpackage

// File: rtl/mem_mover.sv
// Memory mover: copies a block between two wrapping address ranges of a small
// memory, or fills a range with a constant, keeping a running byte sum.
//
// state | meaning
// IDLE  | waiting for iStart, memory port quiet
// READ  | copy only: fetch source byte into the buffer
// WRITE | store buffer (copy) or fill byte (fill) at destination
// DONE  | one-cycle completion pulse, memory port quiet
module mem_mover
    import mem_mover_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iStart,
    input  logic          iMode,
    input  logic [AW-1:0] iSrc,
    input  logic [AW-1:0] iDst,
    input  logic [AW-1:0] iLen,
    input  logic [DW-1:0] iFill,
    output logic          oBusy,
    output logic          oDone,
    output logic [DW-1:0] oSum,
    output logic          oMemWR,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemData,
    input  logic [DW-1:0] iMemData
);

    stateT         state;
    stateT         stateNext;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [DW-1:0] fill;
    logic [DW-1:0] sum;
    logic [DW-1:0] buffer;
    logic [DW-1:0] wrData;
    logic [AW:0]   idx;
    logic [AW:0]   idxNext;
    logic [AW:0]   byteCount;
    logic          lastByte;
    logic          wrEn;

    // A zero length encodes a full sweep of the address space.
    assign byteCount = (len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, len};
    assign idxNext   = idx + 1'b1;
    assign lastByte  = (idxNext == byteCount);
    assign wrData    = (mode == MODE_FILL) ? fill : buffer;
    assign oSum      = sum;
    // The strobe is masked by reset so an aborted transfer never writes.
    assign oMemWR    = wrEn & ~iRst;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= IDLE;
            mode   <= MODE_COPY;
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            fill   <= '0;
            sum    <= '0;
            buffer <= '0;
            idx    <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        mode <= iMode;
                        src  <= iSrc;
                        dst  <= iDst;
                        len  <= iLen;
                        fill <= iFill;
                        sum  <= '0;
                        idx  <= '0;
                    end
                end
                READ: buffer <= iMemData;
                WRITE: begin
                    sum <= sum + wrData;
                    idx <= idxNext;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        wrEn      = 1'b0;
        oMemAddr  = '0;
        oMemData  = '0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    stateNext = (iMode == MODE_FILL) ? WRITE : READ;
                end
            end
            READ: begin
                oBusy     = 1'b1;
                oMemAddr  = src + idx[AW-1:0];
                stateNext = WRITE;
            end
            WRITE: begin
                oBusy    = 1'b1;
                wrEn     = 1'b1;
                oMemAddr = dst + idx[AW-1:0];
                oMemData = wrData;
                if (lastByte) begin
                    stateNext = DONE;
                end else begin
                    stateNext = (mode == MODE_FILL) ? WRITE : READ;
                end
            end
            DONE: begin
                oDone     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_mover.sv
// Scoreboard bench for mem_mover: a 16x8 memory model, a high-level transfer
// reference model feeding expectation queues, and a negedge monitor.
module tb_mem_mover;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wrT;

    typedef struct {
        logic [7:0] sum;
        int         busy;
    } doneT;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iStart;
    logic       iMode;
    logic [3:0] iSrc;
    logic [3:0] iDst;
    logic [3:0] iLen;
    logic [7:0] iFill;
    logic       oBusy;
    logic       oDone;
    logic [7:0] oSum;
    logic       oMemWR;
    logic [3:0] oMemAddr;
    logic [7:0] oMemData;
    logic [7:0] iMemData;

    logic [7:0] mem    [16];
    logic [7:0] refMem [16];
    logic       pokeEn;
    logic [3:0] pokeAddr;
    logic [7:0] pokeData;

    wrT   wrQ[$];
    doneT doneQ[$];
    int   errors = 0;
    int   checks = 0;
    int   busyCnt = 0;
    int   doneSeen = 0;
    int   expDones = 0;

    always #5 iClk = ~iClk;

    mem_mover dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iMode   (iMode),
        .iSrc    (iSrc),
        .iDst    (iDst),
        .iLen    (iLen),
        .iFill   (iFill),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oSum    (oSum),
        .oMemWR  (oMemWR),
        .oMemAddr(oMemAddr),
        .oMemData(oMemData),
        .iMemData(iMemData)
    );

    // 16x8 data memory: combinational read, write on the falling edge.
    assign iMemData = mem[oMemAddr];

    always @(negedge iClk) begin
        if (oMemWR) mem[oMemAddr] <= oMemData;
        else if (pokeEn) mem[pokeAddr] <= pokeData;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT writes or completes.
    always @(negedge iClk) begin
        wrT   w;
        doneT d;
        if (iRst) begin
            busyCnt = 0;
            chk("wr_during_reset", {31'd0, oMemWR}, 32'd0);
        end else begin
            if (oMemWR) begin
                if (wrQ.size() == 0) begin
                    chk("unexpected_write_addr", {28'd0, oMemAddr}, 32'hFFFF_FFFF);
                end else begin
                    w = wrQ.pop_front();
                    chk("wr_addr", {28'd0, oMemAddr}, {28'd0, w.addr});
                    chk("wr_data", {24'd0, oMemData}, {24'd0, w.data});
                end
            end
            if (oBusy) busyCnt++;
            else chk("quiet_port", {19'd0, oMemWR, oMemAddr, oMemData}, 32'd0);
            if (oDone) begin
                doneSeen++;
                if (doneQ.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    d = doneQ.pop_front();
                    chk("done_sum", {24'd0, oSum}, {24'd0, d.sum});
                    chk("busy_cycles", busyCnt, d.busy);
                    chk("mem_image", {31'd0, (mem == refMem)}, 32'd1);
                end
                busyCnt = 0;
            end
        end
    end

    // Reference model: applies up to 'limit' bytes of the transfer to refMem.
    task automatic modelXfer(input logic m, input logic [3:0] s, input logic [3:0] d,
                             input logic [3:0] l, input logic [7:0] f, input int limit);
        int         n;
        logic [7:0] total;
        logic [7:0] b;
        wrT         w;
        doneT       dr;
        n = (l == 0) ? 16 : int'(l);
        total = 8'd0;
        for (int i = 0; i < n && i < limit; i++) begin
            b = m ? f : refMem[(int'(s) + i) % 16];
            w.addr = 4'((int'(d) + i) % 16);
            w.data = b;
            refMem[w.addr] = b;
            total = total + b;
            wrQ.push_back(w);
        end
        if (limit >= n) begin
            dr.sum  = total;
            dr.busy = m ? n : 2 * n;
            doneQ.push_back(dr);
            expDones++;
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] v);
        pokeAddr = a;
        pokeData = v;
        pokeEn   = 1'b1;
        refMem[a] = v;
        @(posedge iClk); #1;
        pokeEn = 1'b0;
    endtask

    // Runs one transfer while scrambling inputs (and iStart) until completion.
    task automatic runXfer(input logic m, input logic [3:0] s, input logic [3:0] d,
                           input logic [3:0] l, input logic [7:0] f);
        bit seen;
        iMode = m; iSrc = s; iDst = d; iLen = l; iFill = f;
        iStart = 1'b1;
        modelXfer(m, s, d, l, f, 99);
        @(posedge iClk); #1;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            iStart = 1'($urandom);
            iMode  = 1'($urandom);
            iSrc   = 4'($urandom);
            iDst   = 4'($urandom);
            iLen   = 4'($urandom);
            iFill  = 8'($urandom);
            @(posedge iClk); #1;
            seen = oDone;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        chk("idle_after_done", {30'd0, oBusy, oDone}, 32'd0);
    endtask

    initial begin
        iRst = 1'b1; iStart = 1'b0; iMode = 1'b0;
        iSrc = '0; iDst = '0; iLen = '0; iFill = '0;
        pokeEn = 1'b0; pokeAddr = '0; pokeData = '0;
        for (int i = 0; i < 16; i++) poke(4'(i), 8'h00);
        @(posedge iClk); #1;
        chk("reset_busy", {31'd0, oBusy}, 32'd0);
        chk("reset_done", {31'd0, oDone}, 32'd0);
        chk("reset_sum", {24'd0, oSum}, 32'd0);
        iRst = 1'b0;
        @(posedge iClk); #1;

        poke(4'd0, 8'h02);
        poke(4'd1, 8'h80);
        runXfer(1'b0, 4'd0, 4'd4, 4'd2, 8'h00);
        chk("copy_sum", {24'd0, oSum}, 32'h82);
        chk("copy_mem4", {24'd0, mem[4]}, 32'h02);
        chk("copy_mem5", {24'd0, mem[5]}, 32'h80);

        runXfer(1'b1, 4'd0, 4'd14, 4'd4, 8'hAA);
        chk("fill_wrap_sum", {24'd0, oSum}, 32'hA8);
        chk("fill_wrap_mem1", {24'd0, mem[1]}, 32'hAA);

        runXfer(1'b1, 4'd0, 4'd9, 4'd0, 8'h11);
        chk("fill16_sum", {24'd0, oSum}, 32'h10);
        chk("fill16_mem8", {24'd0, mem[8]}, 32'h11);

        poke(4'd0, 8'h02);
        poke(4'd1, 8'h80);
        poke(4'd2, 8'h00);
        runXfer(1'b0, 4'd0, 4'd1, 4'd3, 8'h00);
        chk("overlap_sum", {24'd0, oSum}, 32'h06);
        chk("overlap_mem3", {24'd0, mem[3]}, 32'h02);

        // Reset during the second write of a 4-byte fill.
        iMode = 1'b1; iSrc = 4'd0; iDst = 4'd8; iLen = 4'd4; iFill = 8'h5C;
        iStart = 1'b1;
        modelXfer(1'b1, 4'd0, 4'd8, 4'd4, 8'h5C, 1);
        @(posedge iClk); #1;
        iStart = 1'b0;
        @(posedge iClk); #1;
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        chk("abort_busy", {31'd0, oBusy}, 32'd0);
        chk("abort_sum", {24'd0, oSum}, 32'd0);
        repeat (3) @(posedge iClk);
        #1;
        chk("abort_mem9", {24'd0, mem[9]}, 32'h11);
        chk("abort_image", {31'd0, (mem == refMem)}, 32'd1);

        for (int i = 0; i < 16; i++) poke(4'(i), 8'($urandom));
        for (int t = 0; t < 30; t++) begin
            runXfer(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge iClk);
            #1;
        end

        repeat (3) @(posedge iClk);
        #1;
        chk("done_count", doneSeen, expDones);
        chk("writes_left", wrQ.size(), 32'd0);
        chk("dones_left", doneQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
